// File: rtl/alu_issue_unit_if.sv
// Bundle between the issuing sequencer, the ALU issue unit and the ALU instance.
// The unit takes the slave modport; the sequencer/ALU environment takes master.
interface alu_issue_unit_if #(
  parameter int TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       alu_ctl;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_out;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b, req_tag,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_ctl, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_zero, rsp_error, rsp_tag
  );

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b, req_tag,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_ctl, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_zero, rsp_error, rsp_tag
  );
endinterface

// File: rtl/alu_issue_unit.sv
// MIPS ALU issue unit: decodes ALUOp/funct, holds ALU inputs for SETTLE_CYCLES, returns result.
// Define ALU_ISSUE_CHECK_EN to add a reference model that flags ALU mismatches on chk_fail.
module alu_issue_unit #(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4
) (
  input  logic             clock,
  input  logic             reset,
  alu_issue_unit_if.slave  bus,
  output logic             chk_fail
);
  localparam int DATA_W = 32;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  dec_ctl;
  logic        dec_illegal;
  logic        accept;
  logic        capture;

  // Returns {illegal, ctl}; illegal ops report ctl 0000 but it is never issued.
  function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
    logic [4:0] r;
    r = 5'b1_0000;
    case (aluop)
      2'b00: r = 5'b0_0010;
      2'b01: r = 5'b0_0110;
      2'b10: begin
        case (funct)
          6'b100000: r = 5'b0_0010;
          6'b100010: r = 5'b0_0110;
          6'b100100: r = 5'b0_0000;
          6'b100101: r = 5'b0_0001;
          6'b101010: r = 5'b0_0111;
          6'b100111: r = 5'b0_1100;
          default:   r = 5'b1_0000;
        endcase
      end
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  always_comb {dec_illegal, dec_ctl} = decode(bus.req_aluop, bus.req_funct);

  assign accept  = (state == IDLE) && bus.req_valid;
  assign capture = (state == EXEC) && (cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = dec_illegal ? RESP : EXEC;
      end
      EXEC: if (cnt == CNT_LAST) state_nxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- issue / capture registers ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.alu_ctl    <= 4'b0000;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_error  <= 1'b0;
      bus.rsp_tag    <= '0;
      cnt            <= 4'd0;
    end else if (accept) begin
      bus.alu_a   <= bus.req_a;
      bus.alu_b   <= bus.req_b;
      bus.rsp_tag <= bus.req_tag;
      cnt         <= 4'd0;
      if (dec_illegal) begin
        bus.rsp_error  <= 1'b1;
        bus.rsp_result <= '0;
        bus.rsp_zero   <= 1'b0;
      end else begin
        bus.alu_ctl <= dec_ctl;
      end
    end else if (state == EXEC) begin
      cnt <= cnt + 4'd1;
      if (capture) begin
        bus.rsp_result <= bus.alu_out;
        bus.rsp_zero   <= bus.alu_zero;
        bus.rsp_error  <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  function automatic logic [DATA_W-1:0] ref_result(input logic [3:0] ctl,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [DATA_W-1:0] r;
    sa = a;
    sb = b;
    case (ctl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = (sa < sb) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
      4'b1100: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] exp_result;
  assign exp_result = ref_result(bus.alu_ctl, bus.alu_a, bus.alu_b);

  // Only legal ops reach EXEC, so capture never checks an illegal request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) chk_fail <= 1'b0;
    else if (capture &&
             ((bus.alu_out != exp_result) || (bus.alu_zero != (exp_result == '0))))
      chk_fail <= 1'b1;
  end
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: table of single ops on a SETTLE_CYCLES=1 unit,
// plus hand sequences for response backpressure, long settle and mid-flight reset.
module tb_alu_issue_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fault1 = 1'b0;
  logic chk1, chk4;
  logic both_seen = 1'b0;
  logic rsp4_seen = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  alu_issue_unit_if #(.TAG_W(4)) if1 ();
  alu_issue_unit_if #(.TAG_W(4)) if4 ();

  alu_issue_unit #(.SETTLE_CYCLES(1), .TAG_W(4)) dut1 (
    .clock(clk), .reset(rst_n), .bus(if1), .chk_fail(chk1));
  alu_issue_unit #(.SETTLE_CYCLES(4), .TAG_W(4)) dut4 (
    .clock(clk), .reset(rst_n), .bus(if4), .chk_fail(chk4));

  function automatic logic [31:0] alu_fn(input logic [3:0] ctl, input logic [31:0] a,
                                         input logic [31:0] b);
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Bench-side ALUs; fault1 corrupts bit 0 of the first one.
  assign if1.alu_out  = alu_fn(if1.alu_ctl, if1.alu_a, if1.alu_b) ^ {31'b0, fault1};
  assign if1.alu_zero = (if1.alu_out == 32'd0);
  assign if4.alu_out  = alu_fn(if4.alu_ctl, if4.alu_a, if4.alu_b);
  assign if4.alu_zero = (if4.alu_out == 32'd0);

  always @(negedge clk) begin
    if ((if1.req_ready && if1.rsp_valid) || (if4.req_ready && if4.rsp_valid)) both_seen = 1'b1;
  end

  typedef struct {
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] result;
    logic        zero;
    logic        error;
    int          lat;
    logic [3:0]  ctl;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue1(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, output int edges);
    @(negedge clk);
    check("req_ready before accept", {31'b0, if1.req_ready}, 32'd1);
    if1.req_valid = 1'b1;
    if1.req_aluop = op;
    if1.req_funct = fn;
    if1.req_a     = a;
    if1.req_b     = b;
    if1.req_tag   = tag;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    edges = 1;
    while (!if1.rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic release1;
    @(negedge clk);
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_valid after handoff", {31'b0, if1.rsp_valid}, 32'd0);
    check("req_ready after handoff", {31'b0, if1.req_ready}, 32'd1);
    @(negedge clk);
    if1.rsp_ready = 1'b0;
  endtask

  initial begin
    int edges;
    vecs[0]  = '{2'b10, 6'b100100, 32'h55555555, 32'h55555555, 4'h3, 32'h55555555, 1'b0, 1'b0, 2, 4'b0000};
    vecs[1]  = '{2'b10, 6'b100101, 32'h55555555, 32'h55555555, 4'h4, 32'h55555555, 1'b0, 1'b0, 2, 4'b0001};
    vecs[2]  = '{2'b10, 6'b100000, 32'h55555555, 32'h55555555, 4'h5, 32'hAAAAAAAA, 1'b0, 1'b0, 2, 4'b0010};
    vecs[3]  = '{2'b00, 6'b111111, 32'h55555555, 32'h55555555, 4'h6, 32'hAAAAAAAA, 1'b0, 1'b0, 2, 4'b0010};
    vecs[4]  = '{2'b01, 6'b000000, 32'h55555555, 32'h55555555, 4'h7, 32'h00000000, 1'b1, 1'b0, 2, 4'b0110};
    vecs[5]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'h00000001, 4'h8, 32'h00000001, 1'b0, 1'b0, 2, 4'b0111};
    vecs[6]  = '{2'b10, 6'b000000, 32'h12345678, 32'h9ABCDEF0, 4'h9, 32'h00000000, 1'b0, 1'b1, 1, 4'b0111};
    vecs[7]  = '{2'b11, 6'b100000, 32'h00000001, 32'h00000001, 4'hA, 32'h00000000, 1'b0, 1'b1, 1, 4'b0111};
    vecs[8]  = '{2'b10, 6'b100111, 32'h0F0F0F0F, 32'h00FF00FF, 4'hB, 32'hF000F000, 1'b0, 1'b0, 2, 4'b1100};
    vecs[9]  = '{2'b10, 6'b100010, 32'h00000005, 32'h00000007, 4'hC, 32'hFFFFFFFE, 1'b0, 1'b0, 2, 4'b0110};
    vecs[10] = '{2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 4'hD, 32'h00000000, 1'b1, 1'b0, 2, 4'b0111};

    if1.req_valid = 1'b0; if1.req_aluop = '0; if1.req_funct = '0;
    if1.req_a = '0; if1.req_b = '0; if1.req_tag = '0; if1.rsp_ready = 1'b0;
    if4.req_valid = 1'b0; if4.req_aluop = '0; if4.req_funct = '0;
    if4.req_a = '0; if4.req_b = '0; if4.req_tag = '0; if4.rsp_ready = 1'b0;

    #12;
    check("reset req_ready", {31'b0, if1.req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, if1.rsp_valid}, 32'd0);
    check("reset alu_ctl", {28'b0, if1.alu_ctl}, 32'd0);
    check("reset alu_a", if1.alu_a, 32'd0);
    check("reset rsp_result", if1.rsp_result, 32'd0);
    check("reset rsp_tag", {28'b0, if1.rsp_tag}, 32'd0);
    check("reset chk_fail", {31'b0, chk1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue1(vecs[i].aluop, vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].tag, edges);
      check($sformatf("v%0d latency", i), edges, vecs[i].lat);
      check($sformatf("v%0d rsp_result", i), if1.rsp_result, vecs[i].result);
      check($sformatf("v%0d rsp_zero", i), {31'b0, if1.rsp_zero}, {31'b0, vecs[i].zero});
      check($sformatf("v%0d rsp_error", i), {31'b0, if1.rsp_error}, {31'b0, vecs[i].error});
      check($sformatf("v%0d rsp_tag", i), {28'b0, if1.rsp_tag}, {28'b0, vecs[i].tag});
      check($sformatf("v%0d alu_ctl", i), {28'b0, if1.alu_ctl}, {28'b0, vecs[i].ctl});
      release1();
    end
    check("chk_fail clean run", {31'b0, chk1}, 32'd0);

    // Backpressure: response held 5 cycles while a new request waits.
    issue1(2'b10, 6'b100000, 32'h55555555, 32'h55555555, 4'h9, edges);
    if1.req_valid = 1'b1; if1.req_aluop = 2'b00; if1.req_a = 32'd1; if1.req_b = 32'd2;
    if1.req_tag = 4'hA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold rsp_valid", {31'b0, if1.rsp_valid}, 32'd1);
      check("hold req_ready", {31'b0, if1.req_ready}, 32'd0);
      check("hold rsp_result", if1.rsp_result, 32'hAAAAAAAA);
      check("hold rsp_tag", {28'b0, if1.rsp_tag}, 32'h9);
    end
    if1.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    if1.rsp_ready = 1'b0;
    check("hold release rsp_valid", {31'b0, if1.rsp_valid}, 32'd0);
    check("hold release req_ready", {31'b0, if1.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    check("queued req accepted", {31'b0, if1.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("queued rsp_valid", {31'b0, if1.rsp_valid}, 32'd1);
    check("queued rsp_result", if1.rsp_result, 32'd3);
    check("queued rsp_tag", {28'b0, if1.rsp_tag}, 32'hA);
    release1();

    // Long settle window: response 5 edges after accept.
    @(negedge clk);
    if4.req_valid = 1'b1; if4.req_aluop = 2'b00; if4.req_a = 32'd1; if4.req_b = 32'd2;
    if4.req_tag = 4'h2;
    @(posedge clk);
    #1;
    if4.req_valid = 1'b0;
    edges = 1;
    while (!if4.rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("settle4 latency", edges, 5);
    check("settle4 rsp_result", if4.rsp_result, 32'd3);
    @(negedge clk);
    if4.rsp_ready = 1'b1;
    @(negedge clk);
    if4.rsp_ready = 1'b0;

    // Reset in the middle of EXEC drops the transaction.
    @(negedge clk);
    if4.req_valid = 1'b1; if4.req_aluop = 2'b10; if4.req_funct = 6'b100101;
    if4.req_a = 32'hF0; if4.req_b = 32'h0F; if4.req_tag = 4'h5;
    @(posedge clk);
    #1;
    if4.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("exec req_ready", {31'b0, if4.req_ready}, 32'd0);
    check("exec rsp_valid", {31'b0, if4.rsp_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst req_ready", {31'b0, if4.req_ready}, 32'd1);
    check("async rst rsp_valid", {31'b0, if4.rsp_valid}, 32'd0);
    check("async rst alu_ctl", {28'b0, if4.alu_ctl}, 32'd0);
    check("async rst alu_a", if4.alu_a, 32'd0);
    check("async rst alu_b", if4.alu_b, 32'd0);
    check("async rst rsp_result", if4.rsp_result, 32'd0);
    check("async rst rsp_tag", {28'b0, if4.rsp_tag}, 32'd0);
    check("async rst dut1 rsp_result", if1.rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if4.rsp_valid) rsp4_seen = 1'b1;
    end
    check("no response after reset", {31'b0, rsp4_seen}, 32'd0);
    check("chk_fail settle4", {31'b0, chk4}, 32'd0);

`ifdef ALU_ISSUE_CHECK_EN
    fault1 = 1'b1;
    issue1(2'b00, 6'b000000, 32'd1, 32'd1, 4'h1, edges);
    check("chk_fail on bad alu", {31'b0, chk1}, 32'd1);
    release1();
    fault1 = 1'b0;
    issue1(2'b00, 6'b000000, 32'd1, 32'd1, 4'h2, edges);
    check("chk_fail sticky", {31'b0, chk1}, 32'd1);
    release1();
`endif

    check("ready/valid exclusive", {31'b0, both_seen}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Driver-side front end for the single-cycle MIPS ALU: the issuing end of the ALU interface, the counterpart of the ALU itself.
- Accepts operation requests (ALUOp + funct + operands) over a valid/ready handshake and decodes them to the 4-bit ALU control code.
- Holds the ALU inputs stable for a settle window, then captures ALUOut/Zero into a response register returned over a second valid/ready handshake.
- Sits between the control/datapath sequencer and the ALU instance.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held before capture (legal 1..15)
TAG_W, 4, width of the request/response tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_aluop  in  2  MIPS ALUOp: 00 add, 01 sub, 10 R-type via funct, 11 illegal
req_funct  in  6  R-type funct field
req_a  in  32  operand A
req_b  in  32  operand B
req_tag  in  TAG_W  opaque tag, returned with the result
alu_ctl  out  4  ALU control code to ALU
alu_a  out  32  operand A to ALU
alu_b  out  32  operand B to ALU
alu_out  in  32  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  captured ALU result
rsp_zero  out  1  captured zero flag
rsp_error  out  1  request was an illegal op
rsp_tag  out  TAG_W  tag of the request
chk_fail  out  1  sticky self-check failure (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; req_ready=1; rsp_valid=0.
  - alu_ctl=0000, alu_a=alu_b=0.
  - rsp_result=0, rsp_zero=0, rsp_error=0, rsp_tag=0.
  - settle counter=0, chk_fail=0.
- Decode table:
  - ALUOp 00 -> 0010; ALUOp 01 -> 0110.
  - ALUOp 10, funct 100000 -> 0010 (add); 100010 -> 0110 (sub); 100100 -> 0000 (and); 100101 -> 0001 (or); 101010 -> 0111 (slt); 100111 -> 1100 (nor).
  - Any other funct, or ALUOp 11 -> illegal.
- FSM states IDLE, EXEC, RESP:
  - IDLE: req_ready=1. On req_valid & req_ready, register operands, decoded alu_ctl and tag; clear counter.
    - Legal op -> EXEC.
    - Illegal op -> RESP directly with rsp_error=1, rsp_result=0, rsp_zero=0; alu_ctl unchanged.
  - EXEC: req_ready=0; alu_a/alu_b/alu_ctl held constant; counter increments each cycle.
    - When counter == SETTLE_CYCLES-1, capture alu_out -> rsp_result and alu_zero -> rsp_zero, set rsp_error=0 -> RESP.
  - RESP: rsp_valid=1; all rsp_* held stable while rsp_ready=0.
    - On rsp_ready=1: rsp_valid falls next edge -> IDLE.
- Latency: accept edge to rsp_valid = SETTLE_CYCLES+1 clock edges for a legal op; 1 edge for an illegal op.
- Throughput: one request in flight. req_ready is 1 only in IDLE, so the next request is accepted no earlier than the cycle after response handoff.
- alu_* outputs retain the last issued values in IDLE and RESP (no glitching back to 0).
- rsp_valid and req_ready are never both 1.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values; the in-flight transaction is dropped with no response.
- rsp_ready high outside RESP: ignored.

Optional Feature:
- Macro ALU_ISSUE_CHECK_EN.
- Defined: an internal reference model computes the expected result for the registered op (32-bit wrap add/sub, and, or, nor, signed slt -> 0/1) and expected zero.
  - At capture, any mismatch against alu_out/alu_zero sets chk_fail=1 on that edge; it stays set until reset.
  - Illegal ops are not checked.
- Not defined: no model logic; chk_fail tied to 0.

Test Plan:
- Reset, then A=B=0x55555555, ALUOp 10, funct 100100, SETTLE_CYCLES=1 -> rsp_result=0x55555555, rsp_zero=0, rsp_valid 2 edges after accept, rsp_tag echoed.
- Same operands, funct 100101 (or) then 100000 (add) -> 0x55555555 then 0xAAAAAAAA, zero=0 both; add also via ALUOp 00 -> 0xAAAAAAAA.
- Same operands, ALUOp 01 (sub) -> rsp_result=0x00000000, rsp_zero=1; A=0xFFFFFFFF, B=1, funct 101010 -> result 1 (signed slt).
- ALUOp 10, funct 000000, and separately ALUOp 11 -> rsp_error=1, rsp_result=0, rsp_valid 1 edge after accept, alu_ctl unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 and new req_valid not accepted; then rsp_ready=1 -> IDLE, next request accepted.
- Assert reset low mid-EXEC with SETTLE_CYCLES=4 -> all outputs at reset values without a clock edge, no response emitted. With ALU_ISSUE_CHECK_EN defined and a bench ALU forcing a wrong alu_out -> chk_fail=1 and sticky.
